counter_seq_checker: RTL and testbench

- Receiving-end monitor for the 8-bit enable-gated up-counter.
- Samples the counter's result, enable and reset lines every clock and rebuilds the expected count.
- Flags and counts any deviation, and hands each error record to a consumer through a valid/ready port.
- Sits beside the counter in integration benches and in-system self-checks.

---
 rtl/counter_seq_checker.sv | 144 ++++++++++++++
 tb/tb_counter_seq_checker.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_checker.sv
// Receiving-end monitor for an enable-gated up-counter.
// It rebuilds the expected count, counts mismatches and wraps, and offers each error record on a valid/ready port.
module counter_seq_checker #(
    parameter int WIDTH       = 8,
    parameter int ERR_CNT_W   = 8,
    parameter int WRAP_CNT_W  = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chk_en,
    input  logic                  mon_reset,
    input  logic                  mon_ena,
    input  logic [WIDTH-1:0]      mon_result,
    output logic                  locked,
    output logic                  halted,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  err_valid,
    input  logic                  err_ready,
    output logic [WIDTH-1:0]      err_expected,
    output logic [WIDTH-1:0]      err_actual,
    output logic                  err_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      prev_val_q, prev_val_d;
    logic                  prev_ena_q, prev_ena_d;
    logic                  locked_q, locked_d;
    logic                  halted_q, halted_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
    logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic                  err_valid_q, err_valid_d;
    logic [WIDTH-1:0]      err_expected_q, err_expected_d;
    logic [WIDTH-1:0]      err_actual_q, err_actual_d;
    logic                  err_overflow_q, err_overflow_d;

    logic [WIDTH-1:0]      expected;
    logic                  mismatch;
    logic                  wrap_seen;
    logic                  consume;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can infer a latch.
        state_d        = state_q;
        prev_val_d     = prev_val_q;
        prev_ena_d     = prev_ena_q;
        err_count_d    = err_count_q;
        wrap_count_d   = wrap_count_q;
        err_valid_d    = err_valid_q;
        err_expected_d = err_expected_q;
        err_actual_d   = err_actual_q;
        err_overflow_d = err_overflow_q;
        mismatch       = 1'b0;
        wrap_seen      = 1'b0;
        consume        = err_valid_q & err_ready;
        expected       = mon_reset ? '0 : (prev_ena_q ? prev_val_q + WIDTH'(1) : prev_val_q);

        if (!chk_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_SYNC;
                S_SYNC: begin
                    prev_val_d = mon_reset ? '0 : mon_result;
                    prev_ena_d = mon_ena;
                    state_d    = S_TRACK;
                end
                S_TRACK: begin
                    mismatch   = (mon_result != expected);
                    wrap_seen  = (prev_val_q == '1) && prev_ena_q && (mon_result == '0) && !mon_reset;
                    prev_val_d = mon_reset ? '0 : mon_result;
                    prev_ena_d = mon_ena;
                    if (mismatch && STOP_ON_ERR) state_d = S_HALT;
                end
                S_HALT: if (mon_reset) state_d = S_SYNC;
                default: state_d = S_IDLE;
            endcase
        end

        if (mismatch && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_W'(1);
        if (wrap_seen && (wrap_count_q != '1)) wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);

        // A consume on the same edge frees the slot for a new record.
        if (mismatch) begin
            if (!err_valid_q || consume) begin
                err_valid_d    = 1'b1;
                err_expected_d = expected;
                err_actual_d   = mon_result;
            end else begin
                err_overflow_d = 1'b1;
            end
        end else if (consume) begin
            err_valid_d = 1'b0;
        end

        locked_d = (state_d == S_TRACK);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking only, so every register samples pre-edge values.
        if (reset) begin
            state_q        <= S_IDLE;
            prev_val_q     <= '0;
            prev_ena_q     <= 1'b0;
            locked_q       <= 1'b0;
            halted_q       <= 1'b0;
            err_count_q    <= '0;
            wrap_count_q   <= '0;
            err_valid_q    <= 1'b0;
            err_expected_q <= '0;
            err_actual_q   <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_val_q     <= prev_val_d;
            prev_ena_q     <= prev_ena_d;
            locked_q       <= locked_d;
            halted_q       <= halted_d;
            err_count_q    <= err_count_d;
            wrap_count_q   <= wrap_count_d;
            err_valid_q    <= err_valid_d;
            err_expected_q <= err_expected_d;
            err_actual_q   <= err_actual_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign locked       = locked_q;
    assign halted       = halted_q;
    assign err_count    = err_count_q;
    assign wrap_count   = wrap_count_q;
    assign err_valid    = err_valid_q;
    assign err_expected = err_expected_q;
    assign err_actual   = err_actual_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: one instance keeps checking after errors, the other halts on the first error.
module tb_counter_seq_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chk_en = 1'b0;
    logic       mon_reset = 1'b0;
    logic       mon_ena = 1'b0;
    logic [7:0] mon_result = 8'h00;
    logic       err_ready = 1'b0;

    logic       locked [2];
    logic       halted [2];
    logic [7:0] err_count [2];
    logic [7:0] wrap_count [2];
    logic       err_valid [2];
    logic [7:0] err_expected [2];
    logic [7:0] err_actual [2];
    logic       err_overflow [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Ideal counter driving the monitored lines.
    logic [7:0] cnt_last = 8'h00;
    logic       cnt_ena = 1'b0;

    always #5 clk = ~clk;

    counter_seq_checker #(.WIDTH(8), .ERR_CNT_W(8), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .reset(reset), .chk_en(chk_en), .mon_reset(mon_reset), .mon_ena(mon_ena),
        .mon_result(mon_result), .locked(locked[0]), .halted(halted[0]), .err_count(err_count[0]),
        .wrap_count(wrap_count[0]), .err_valid(err_valid[0]), .err_ready(err_ready),
        .err_expected(err_expected[0]), .err_actual(err_actual[0]), .err_overflow(err_overflow[0])
    );

    counter_seq_checker #(.WIDTH(8), .ERR_CNT_W(8), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .chk_en(chk_en), .mon_reset(mon_reset), .mon_ena(mon_ena),
        .mon_result(mon_result), .locked(locked[1]), .halted(halted[1]), .err_count(err_count[1]),
        .wrap_count(wrap_count[1]), .err_valid(err_valid[1]), .err_ready(err_ready),
        .err_expected(err_expected[1]), .err_actual(err_actual[1]), .err_overflow(err_overflow[1])
    );

    // Reference model: checker behaviour stated as plain rules over a mode and integer counters.
    typedef enum int {M_IDLE, M_SYNC, M_TRACK, M_HALT} mode_e;
    typedef struct {
        mode_e      st;
        logic [7:0] pv;
        logic       pe;
        int         errc;
        int         wrapc;
        logic       ev;
        logic [7:0] ee;
        logic [7:0] ea;
        logic       ov;
    } model_t;

    model_t mdl [2];

    function automatic model_t model_step(model_t m, bit stop);
        model_t     n = m;
        logic [7:0] exp_v = 8'h00;
        bit         err = 1'b0;
        bit         consume;
        if (reset) begin
            n.st = M_IDLE; n.pv = 8'h00; n.pe = 1'b0; n.errc = 0; n.wrapc = 0;
            n.ev = 1'b0; n.ee = 8'h00; n.ea = 8'h00; n.ov = 1'b0;
            return n;
        end
        consume = m.ev && err_ready;
        if (!chk_en) begin
            n.st = M_IDLE;
        end else begin
            case (m.st)
                M_IDLE: n.st = M_SYNC;
                M_SYNC: begin
                    n.pv = mon_reset ? 8'h00 : mon_result;
                    n.pe = mon_ena;
                    n.st = M_TRACK;
                end
                M_TRACK: begin
                    exp_v = mon_reset ? 8'h00 : 8'((int'(m.pv) + (m.pe ? 1 : 0)) % 256);
                    if (mon_result != exp_v) begin
                        err = 1'b1;
                        if (stop) n.st = M_HALT;
                    end
                    if (m.pv == 8'hFF && m.pe && mon_result == 8'h00 && !mon_reset && n.wrapc < 255)
                        n.wrapc = n.wrapc + 1;
                    n.pv = mon_reset ? 8'h00 : mon_result;
                    n.pe = mon_ena;
                end
                M_HALT: if (mon_reset) n.st = M_SYNC;
                default: n.st = M_IDLE;
            endcase
        end
        if (err) begin
            if (n.errc < 255) n.errc = n.errc + 1;
            if (!m.ev || consume) begin
                n.ev = 1'b1; n.ee = exp_v; n.ea = mon_result;
            end else begin
                n.ov = 1'b1;
            end
        end else if (consume) begin
            n.ev = 1'b0;
        end
        return n;
    endfunction

    task automatic cycle();
        @(posedge clk);
        mdl[0] = model_step(mdl[0], 1'b0);
        mdl[1] = model_step(mdl[1], 1'b1);
        @(negedge clk);
    endtask

    task automatic drive_good(input bit rst, input bit ena);
        mon_reset  = rst;
        mon_result = rst ? 8'h00 : (cnt_ena ? cnt_last + 8'd1 : cnt_last);
        mon_ena    = ena;
        cnt_last   = mon_result;
        cnt_ena    = ena;
        cycle();
    endtask

    task automatic drive_raw(input bit rst, input bit ena, input logic [7:0] v);
        mon_reset  = rst;
        mon_result = v;
        mon_ena    = ena;
        cnt_last   = v;
        cnt_ena    = ena;
        cycle();
    endtask

    // Brings the checker into TRACK so the next sample is expected to equal 'first'.
    task automatic start_track(input bit do_reset, input logic [7:0] first);
        if (do_reset) reset = 1'b1;
        else chk_en = 1'b0;
        drive_good(1'b0, 1'b0);
        reset    = 1'b0;
        chk_en   = 1'b1;
        cnt_last = first - 8'd3;
        cnt_ena  = 1'b1;
        drive_good(1'b0, 1'b1);
        drive_good(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; chk_en = 1'b1; err_ready = 1'b1;
        drive_raw(1'b0, 1'b1, 8'h5A);
        drive_raw(1'b1, 1'b1, 8'h33);
        for (int d = 0; d < 2; d++) begin
            logic [35:0] got;
            got = {locked[d], halted[d], err_count[d], wrap_count[d], err_valid[d],
                   err_expected[d], err_actual[d], err_overflow[d]};
            total_cnt++;
            if (got !== 36'h0) $display("FAIL reset_outputs dut%0d: got %h want 0", d, got);
            else pass_cnt++;
        end
        reset = 1'b0;
    endtask

    task automatic test_count();
        bit saw_valid = 1'b0;
        reset = 1'b1; cnt_last = 8'h00; cnt_ena = 1'b0;
        drive_good(1'b0, 1'b0);
        reset = 1'b0; chk_en = 1'b1; err_ready = 1'b1;
        drive_good(1'b1, 1'b1);
        total_cnt++;
        if (locked[0] !== 1'b0) $display("FAIL count_locked_edge1: got %0b want 0", locked[0]);
        else pass_cnt++;
        drive_good(1'b1, 1'b1);
        total_cnt++;
        if (locked[0] !== 1'b1) $display("FAIL count_locked_edge2: got %0b want 1", locked[0]);
        else pass_cnt++;
        for (int i = 1; i < 20; i++) begin
            drive_good(1'b0, 1'b1);
            if (err_valid[0] !== 1'b0) saw_valid = 1'b1;
        end
        total_cnt++;
        if (saw_valid || err_count[0] !== 8'd0 || locked[0] !== 1'b1)
            $display("FAIL count_clean: saw_valid=%0b err_count=%0d locked=%0b want 0/0/1",
                     saw_valid, err_count[0], locked[0]);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        start_track(1'b0, 8'd252);
        for (int i = 0; i < 10; i++) drive_good(1'b0, 1'b1);
        total_cnt++;
        if (wrap_count[0] !== 8'd1 || err_count[0] !== 8'd0)
            $display("FAIL wrap_count: got wrap=%0d err=%0d want 1/0", wrap_count[0], err_count[0]);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) drive_good(1'b0, 1'b0);
        drive_good(1'b0, 1'b1);
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (err_count[0] !== 8'd0 || err_valid[0] !== 1'b0 || wrap_count[0] !== 8'd1 || locked[0] !== 1'b1)
            $display("FAIL wrap_ena_off: got err=%0d valid=%0b wrap=%0d locked=%0b want 0/0/1/1",
                     err_count[0], err_valid[0], wrap_count[0], locked[0]);
        else pass_cnt++;
    endtask

    task automatic test_single_error();
        start_track(1'b1, 8'h10);
        err_ready = 1'b1;
        drive_raw(1'b0, 1'b1, 8'h42);
        total_cnt++;
        if ({err_valid[0], err_expected[0], err_actual[0], err_count[0]} !== {1'b1, 8'h10, 8'h42, 8'd1})
            $display("FAIL single_record: got v=%0b exp=%h act=%h cnt=%0d want 1/10/42/1",
                     err_valid[0], err_expected[0], err_actual[0], err_count[0]);
        else pass_cnt++;
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (err_valid[0] !== 1'b0 || err_count[0] !== 8'd1)
            $display("FAIL single_consume: got v=%0b cnt=%0d want 0/1", err_valid[0], err_count[0]);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        start_track(1'b1, 8'h05);
        err_ready = 1'b0;
        drive_raw(1'b0, 1'b1, 8'h07);
        total_cnt++;
        if ({err_valid[0], err_expected[0], err_actual[0], err_count[0], err_overflow[0]} !==
            {1'b1, 8'h05, 8'h07, 8'd1, 1'b0})
            $display("FAIL ovf_first: got v=%0b exp=%h act=%h cnt=%0d ovf=%0b want 1/05/07/1/0",
                     err_valid[0], err_expected[0], err_actual[0], err_count[0], err_overflow[0]);
        else pass_cnt++;
        start_track(1'b0, 8'h06);
        drive_raw(1'b0, 1'b1, 8'h09);
        total_cnt++;
        if ({err_valid[0], err_expected[0], err_actual[0], err_count[0], err_overflow[0]} !==
            {1'b1, 8'h05, 8'h07, 8'd2, 1'b1})
            $display("FAIL ovf_drop: got v=%0b exp=%h act=%h cnt=%0d ovf=%0b want 1/05/07/2/1",
                     err_valid[0], err_expected[0], err_actual[0], err_count[0], err_overflow[0]);
        else pass_cnt++;
        err_ready = 1'b1;
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (err_valid[0] !== 1'b0 || err_overflow[0] !== 1'b1 || err_count[0] !== 8'd2)
            $display("FAIL ovf_consume: got v=%0b ovf=%0b cnt=%0d want 0/1/2",
                     err_valid[0], err_overflow[0], err_count[0]);
        else pass_cnt++;
    endtask

    task automatic test_mon_reset();
        start_track(1'b1, 8'h30);
        err_ready = 1'b1;
        drive_good(1'b1, 1'b1);
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (err_count[0] !== 8'd0 || err_valid[0] !== 1'b0)
            $display("FAIL monrst_clean: got cnt=%0d v=%0b want 0/0", err_count[0], err_valid[0]);
        else pass_cnt++;
        start_track(1'b1, 8'h30);
        drive_raw(1'b1, 1'b1, 8'h30);
        total_cnt++;
        if ({err_valid[0], err_expected[0], err_actual[0], err_count[0]} !== {1'b1, 8'h00, 8'h30, 8'd1})
            $display("FAIL monrst_stuck: got v=%0b exp=%h act=%h cnt=%0d want 1/00/30/1",
                     err_valid[0], err_expected[0], err_actual[0], err_count[0]);
        else pass_cnt++;
        drive_good(1'b1, 1'b1);
        total_cnt++;
        if (err_valid[0] !== 1'b0 || err_count[0] !== 8'd1)
            $display("FAIL monrst_after: got v=%0b cnt=%0d want 0/1", err_valid[0], err_count[0]);
        else pass_cnt++;
    endtask

    task automatic test_stop_on_err();
        start_track(1'b1, 8'h20);
        err_ready = 1'b1;
        total_cnt++;
        if (locked[1] !== 1'b1 || halted[1] !== 1'b0)
            $display("FAIL stop_locked: got l=%0b h=%0b want 1/0", locked[1], halted[1]);
        else pass_cnt++;
        drive_raw(1'b0, 1'b1, 8'h55);
        total_cnt++;
        if ({halted[1], locked[1], err_count[1], err_valid[1], err_expected[1], err_actual[1]} !==
            {1'b1, 1'b0, 8'd1, 1'b1, 8'h20, 8'h55})
            $display("FAIL stop_halt: got h=%0b l=%0b cnt=%0d v=%0b exp=%h act=%h want 1/0/1/1/20/55",
                     halted[1], locked[1], err_count[1], err_valid[1], err_expected[1], err_actual[1]);
        else pass_cnt++;
        drive_raw(1'b0, 1'b1, 8'h99);
        total_cnt++;
        if (err_count[1] !== 8'd1 || halted[1] !== 1'b1 || err_valid[1] !== 1'b0 || err_count[0] !== 8'd2)
            $display("FAIL stop_frozen: got cnt1=%0d h=%0b v=%0b cnt0=%0d want 1/1/0/2",
                     err_count[1], halted[1], err_valid[1], err_count[0]);
        else pass_cnt++;
        drive_good(1'b1, 1'b1);
        total_cnt++;
        if (halted[1] !== 1'b0 || locked[1] !== 1'b0)
            $display("FAIL stop_resync: got h=%0b l=%0b want 0/0", halted[1], locked[1]);
        else pass_cnt++;
        drive_good(1'b0, 1'b1);
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (locked[1] !== 1'b1 || err_count[1] !== 8'd1)
            $display("FAIL stop_relock: got l=%0b cnt=%0d want 1/1", locked[1], err_count[1]);
        else pass_cnt++;
        drive_raw(1'b0, 1'b1, 8'hEE);
        total_cnt++;
        if (halted[1] !== 1'b1)
            $display("FAIL stop_halt2: got h=%0b want 1", halted[1]);
        else pass_cnt++;
        reset = 1'b1;
        drive_good(1'b0, 1'b1);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            logic [35:0] got;
            got = {locked[d], halted[d], err_count[d], wrap_count[d], err_valid[d],
                   err_expected[d], err_actual[d], err_overflow[d]};
            total_cnt++;
            if (got !== 36'h0) $display("FAIL stop_reset dut%0d: got %h want 0", d, got);
            else pass_cnt++;
        end
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (locked[1] !== 1'b0) $display("FAIL stop_idle_sync: got l=%0b want 0", locked[1]);
        else pass_cnt++;
        drive_good(1'b0, 1'b1);
        total_cnt++;
        if (locked[1] !== 1'b1) $display("FAIL stop_idle_track: got l=%0b want 1", locked[1]);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        start_track(1'b1, 8'h00);
        err_ready = 1'b0;
        for (int i = 0; i < 260; i++) drive_raw(1'b0, 1'b0, 8'(i + 128));
        total_cnt++;
        if (err_count[0] !== 8'hFF || err_overflow[0] !== 1'b1)
            $display("FAIL saturate: got cnt=%0d ovf=%0b want 255/1", err_count[0], err_overflow[0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        reset = 1'b1;
        drive_good(1'b0, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit rst_l, ena_l;
            chk_en    = ($urandom_range(0, 63) != 0);
            err_ready = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 499) == 0);
            rst_l     = ($urandom_range(0, 15) == 0);
            ena_l     = 1'($urandom_range(0, 1));
            if (!rst_l && $urandom_range(0, 9) == 0)
                drive_raw(1'b0, ena_l, 8'($urandom_range(0, 255)));
            else
                drive_good(rst_l, ena_l);
            reset = 1'b0;
            for (int d = 0; d < 2; d++) begin
                logic [35:0] got, want;
                got  = {locked[d], halted[d], err_count[d], wrap_count[d], err_valid[d],
                        err_expected[d], err_actual[d], err_overflow[d]};
                want = {mdl[d].st == M_TRACK, mdl[d].st == M_HALT, 8'(mdl[d].errc), 8'(mdl[d].wrapc),
                        mdl[d].ev, mdl[d].ee, mdl[d].ea, mdl[d].ov};
                total_cnt++;
                if (got !== want)
                    $display("FAIL random dut%0d cycle %0d: got %h want %h", d, c, got, want);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_single_error();
        test_overflow();
        test_mon_reset();
        test_stop_on_err();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
